// File: rtl/debug_pkg.sv
// Shared defaults and sizing helpers for the debug frame interface
// (debug controllers and the frame loader).
package debug_pkg;

    localparam int          DEBUG_NB_FRAME       = 8;
    localparam int          DEBUG_NB_OUTPUT_SIZE = 32;
    localparam int          DEBUG_NB_ADDR        = 10;
    // MIPS halt opcode marks the end of a downloaded program.
    localparam logic [31:0] DEBUG_END_WORD       = 32'hFFFF_FFFF;

    function automatic int frames_per_word(input int nb_output, input int nb_frame);
        return (nb_output + nb_frame - 1) / nb_frame;
    endfunction

    function automatic int padded_width(input int nb_output, input int nb_frame);
        return frames_per_word(nb_output, nb_frame) * nb_frame;
    endfunction

endpackage

// File: rtl/debug_frame_packer.sv
// Packs incoming frames, least-significant chunk first, into one word and
// pulses word_done_o together with the packed word on the final frame.
module debug_frame_packer
    import debug_pkg::*;
#(
    parameter int NB_FRAME       = DEBUG_NB_FRAME,
    parameter int NB_OUTPUT_SIZE = DEBUG_NB_OUTPUT_SIZE
) (
    input  logic                      clock_i,
    input  logic                      clear_i,
    input  logic                      accept_i,
    input  logic [NB_FRAME-1:0]       frame_i,
    output logic [NB_OUTPUT_SIZE-1:0] word_o,
    output logic                      word_done_o,
    output logic                      busy_o
);

    localparam int FPW       = frames_per_word(NB_OUTPUT_SIZE, NB_FRAME);
    localparam int NB_PADDED = padded_width(NB_OUTPUT_SIZE, NB_FRAME);
    localparam int CNT_W     = (FPW > 1) ? $clog2(FPW) : 1;

    logic [CNT_W-1:0]     count_q, count_d;
    logic [NB_PADDED-1:0] slots_q, slots_d;
    logic                 last;

    always_comb begin
        last    = (count_q == CNT_W'(FPW - 1));
        slots_d = slots_q;
        count_d = count_q;
        if (accept_i) begin
            for (int s = 0; s < FPW; s++) begin
                if (count_q == CNT_W'(s)) slots_d[s*NB_FRAME +: NB_FRAME] = frame_i;
            end
            count_d = last ? '0 : count_q + 1'b1;
        end
        if (clear_i) begin
            slots_d = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clock_i) begin
        count_q <= count_d;
        slots_q <= slots_d;
    end

    // Bits of the last frame above NB_OUTPUT_SIZE are dropped here.
    assign word_o      = slots_d[NB_OUTPUT_SIZE-1:0];
    assign word_done_o = accept_i & last & ~clear_i;
    assign busy_o      = (count_q != '0);

endmodule

// File: rtl/debug_frame_loader.sv
// Host-to-MIPS debug loader: assembles frames into words and writes them to
// instruction memory at consecutive addresses until end word or memory full.
module debug_frame_loader
    import debug_pkg::*;
#(
    parameter int                        NB_FRAME       = DEBUG_NB_FRAME,
    parameter int                        NB_OUTPUT_SIZE = DEBUG_NB_OUTPUT_SIZE,
    parameter int                        NB_ADDR        = DEBUG_NB_ADDR,
    parameter logic [NB_OUTPUT_SIZE-1:0] END_WORD       = NB_OUTPUT_SIZE'(DEBUG_END_WORD)
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_enable,
    input  logic [NB_FRAME-1:0]       i_frame,
    input  logic                      i_frame_valid,
    output logic [NB_OUTPUT_SIZE-1:0] o_data,
    output logic [NB_ADDR-1:0]        o_addr,
    output logic                      o_write_enable,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_full
);

    localparam logic [NB_ADDR-1:0] ADDR_MAX = '1;

    logic                      clear, accept, word_done, packer_busy;
    logic [NB_OUTPUT_SIZE-1:0] word;
    logic [NB_OUTPUT_SIZE-1:0] data_q, data_d;
    logic [NB_ADDR-1:0]        addr_q, addr_d;
    logic                      we_q, we_d, done_q, done_d, full_q, full_d;

    assign clear  = i_reset | ~i_enable;
    assign accept = i_enable & i_frame_valid & ~done_q;

    debug_frame_packer #(
        .NB_FRAME      (NB_FRAME),
        .NB_OUTPUT_SIZE(NB_OUTPUT_SIZE)
    ) u_packer (
        .clock_i    (i_clock),
        .clear_i    (clear),
        .accept_i   (accept),
        .frame_i    (i_frame),
        .word_o     (word),
        .word_done_o(word_done),
        .busy_o     (packer_busy)
    );

    always_comb begin
        data_d = data_q;
        addr_d = addr_q;
        we_d   = word_done;
        done_d = done_q;
        full_d = full_q;
        if (word_done) data_d = word;
        // End word wins over full so a halt on the last address is not "full".
        if (we_q) begin
            if (addr_q != ADDR_MAX) addr_d = addr_q + 1'b1;
            if (data_q == END_WORD) begin
                done_d = 1'b1;
            end else if (addr_q == ADDR_MAX) begin
                done_d = 1'b1;
                full_d = 1'b1;
            end
        end
        if (clear) begin
            data_d = '0;
            addr_d = '0;
            we_d   = 1'b0;
            done_d = 1'b0;
            full_d = 1'b0;
        end
    end

    always_ff @(posedge i_clock) begin
        data_q <= data_d;
        addr_q <= addr_d;
        we_q   <= we_d;
        done_q <= done_d;
        full_q <= full_d;
    end

    // Gating with i_enable zeroes outputs in the very cycle enable drops.
    assign o_data         = i_enable ? data_q : '0;
    assign o_addr         = i_enable ? addr_q : '0;
    assign o_write_enable = i_enable & we_q;
    assign o_busy         = i_enable & ~done_q & packer_busy;
    assign o_done         = i_enable & done_q;
    assign o_full         = i_enable & full_q;

endmodule

// File: tb/tb_debug_frame_loader.sv
// Directed bench for debug_frame_loader: default, 20-bit word and 2-bit
// address instances share stimulus; each test resets and checks one of them.
module tb_debug_frame_loader;

    logic       clk = 1'b0;
    logic       rst, en, vld;
    logic [7:0] frm;

    always #5 clk = ~clk;

    logic [31:0] d0_data; logic [9:0] d0_addr; logic d0_we, d0_busy, d0_done, d0_full;
    logic [19:0] d1_data; logic [9:0] d1_addr; logic d1_we, d1_busy, d1_done, d1_full;
    logic [31:0] d2_data; logic [1:0] d2_addr; logic d2_we, d2_busy, d2_done, d2_full;

    debug_frame_loader dut0 (
        .i_clock(clk), .i_reset(rst), .i_enable(en), .i_frame(frm), .i_frame_valid(vld),
        .o_data(d0_data), .o_addr(d0_addr), .o_write_enable(d0_we),
        .o_busy(d0_busy), .o_done(d0_done), .o_full(d0_full));

    debug_frame_loader #(.NB_OUTPUT_SIZE(20)) dut1 (
        .i_clock(clk), .i_reset(rst), .i_enable(en), .i_frame(frm), .i_frame_valid(vld),
        .o_data(d1_data), .o_addr(d1_addr), .o_write_enable(d1_we),
        .o_busy(d1_busy), .o_done(d1_done), .o_full(d1_full));

    debug_frame_loader #(.NB_ADDR(2)) dut2 (
        .i_clock(clk), .i_reset(rst), .i_enable(en), .i_frame(frm), .i_frame_valid(vld),
        .o_data(d2_data), .o_addr(d2_addr), .o_write_enable(d2_we),
        .o_busy(d2_busy), .o_done(d2_done), .o_full(d2_full));

    int checks = 0;
    int failures = 0;

    // Write logs, sampled mid-cycle.
    int          w0_cnt = 0, w1_cnt = 0, w2_cnt = 0;
    logic [31:0] w0_data [0:63];
    logic [9:0]  w0_addr [0:63];
    logic [31:0] w2_data [0:63];
    logic [1:0]  w2_addr [0:63];

    always @(negedge clk) begin
        if (d0_we) begin
            if (w0_cnt < 64) begin w0_data[w0_cnt] = d0_data; w0_addr[w0_cnt] = d0_addr; end
            w0_cnt++;
        end
        if (d1_we) w1_cnt++;
        if (d2_we) begin
            if (w2_cnt < 64) begin w2_data[w2_cnt] = d2_data; w2_addr[w2_cnt] = d2_addr; end
            w2_cnt++;
        end
    end

    task automatic cycle();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [7:0] f);
        frm = f; vld = 1'b1;
        cycle();
        vld = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b1; vld = 1'b0; frm = 8'h00;
        cycle(); cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (d0_data !== 32'h0) begin failures++; $display("FAIL reset_data got %h exp 0", d0_data); end
        checks++; if (d0_addr !== 10'h0) begin failures++; $display("FAIL reset_addr got %h exp 0", d0_addr); end
        checks++; if ({d0_we, d0_busy, d0_done, d0_full} !== 4'b0) begin failures++;
            $display("FAIL reset_flags got %b exp 0000", {d0_we, d0_busy, d0_done, d0_full}); end
    endtask

    task automatic test_single_word();
        logic [7:0] f [0:3];
        int base;
        f[0] = 8'h78; f[1] = 8'h56; f[2] = 8'h34; f[3] = 8'h12;
        do_reset();
        base = w0_cnt;
        for (int i = 0; i < 3; i++) begin
            send(f[i]);
            checks++; if (d0_busy !== 1'b1) begin failures++; $display("FAIL single_busy%0d got %b exp 1", i, d0_busy); end
            cycle(); cycle();
        end
        checks++; if (d0_we !== 1'b0) begin failures++; $display("FAIL single_we_early got %b exp 0", d0_we); end
        send(f[3]);
        checks++; if (d0_we !== 1'b1) begin failures++; $display("FAIL single_we got %b exp 1", d0_we); end
        checks++; if (d0_data !== 32'h1234_5678) begin failures++; $display("FAIL single_data got %h exp 12345678", d0_data); end
        checks++; if (d0_addr !== 10'd0) begin failures++; $display("FAIL single_addr got %0d exp 0", d0_addr); end
        checks++; if (d0_busy !== 1'b0) begin failures++; $display("FAIL single_busy_end got %b exp 0", d0_busy); end
        cycle();
        checks++; if (d0_we !== 1'b0) begin failures++; $display("FAIL single_we_pulse got %b exp 0", d0_we); end
        checks++; if (d0_data !== 32'h1234_5678) begin failures++; $display("FAIL single_data_hold got %h exp 12345678", d0_data); end
        checks++; if (w0_cnt - base !== 1) begin failures++; $display("FAIL single_writes got %0d exp 1", w0_cnt - base); end
    endtask

    task automatic test_back_to_back_end();
        logic [7:0]  f [0:11];
        logic [31:0] exp_w [0:2];
        int base;
        f[0] = 8'h44; f[1] = 8'h33; f[2] = 8'h22; f[3] = 8'h11;
        f[4] = 8'h0F; f[5] = 8'h0F; f[6] = 8'hA5; f[7] = 8'hA5;
        for (int i = 8; i < 12; i++) f[i] = 8'hFF;
        exp_w[0] = 32'h1122_3344; exp_w[1] = 32'hA5A5_0F0F; exp_w[2] = 32'hFFFF_FFFF;
        do_reset();
        base = w0_cnt;
        for (int i = 0; i < 12; i++) begin frm = f[i]; vld = 1'b1; cycle(); end
        vld = 1'b0;
        cycle();
        checks++; if (w0_cnt - base !== 3) begin failures++; $display("FAIL b2b_writes got %0d exp 3", w0_cnt - base); end
        for (int i = 0; i < 3; i++) begin
            if (base + i < 64 && w0_cnt - base == 3) begin
                checks++; if (w0_data[base+i] !== exp_w[i] || w0_addr[base+i] !== 10'(i)) begin failures++;
                    $display("FAIL b2b_write%0d got %h@%0d exp %h@%0d", i, w0_data[base+i], w0_addr[base+i], exp_w[i], i); end
            end
        end
        checks++; if (d0_done !== 1'b1 || d0_full !== 1'b0) begin failures++;
            $display("FAIL b2b_done_full got %b%b exp 10", d0_done, d0_full); end
        checks++; if (d0_addr !== 10'd3) begin failures++; $display("FAIL b2b_addr_after got %0d exp 3", d0_addr); end
        for (int i = 0; i < 4; i++) send(8'h5A);
        cycle(); cycle();
        checks++; if (w0_cnt - base !== 3 || d0_busy !== 1'b0 || d0_done !== 1'b1) begin failures++;
            $display("FAIL b2b_ignored got writes=%0d busy=%b done=%b exp 3 0 1", w0_cnt - base, d0_busy, d0_done); end
    endtask

    task automatic test_narrow_word();
        int base;
        do_reset();
        base = w1_cnt;
        frm = 8'hCD; vld = 1'b1; cycle();
        frm = 8'hAB; cycle();
        frm = 8'hF9; cycle();
        vld = 1'b0;
        checks++; if (d1_we !== 1'b1) begin failures++; $display("FAIL w20_we got %b exp 1", d1_we); end
        checks++; if (d1_data !== 20'h9ABCD) begin failures++; $display("FAIL w20_data got %h exp 9abcd", d1_data); end
        cycle();
        checks++; if (w1_cnt - base !== 1 || d1_done !== 1'b0) begin failures++;
            $display("FAIL w20_writes got %0d done=%b exp 1 0", w1_cnt - base, d1_done); end
    endtask

    task automatic test_mem_full();
        int base;
        do_reset();
        base = w2_cnt;
        for (int w = 0; w < 4; w++) begin
            frm = 8'(w + 1); vld = 1'b1; cycle();
            frm = 8'h00; cycle(); cycle(); cycle();
        end
        vld = 1'b0;
        cycle();
        checks++; if (w2_cnt - base !== 4) begin failures++; $display("FAIL full_writes got %0d exp 4", w2_cnt - base); end
        for (int i = 0; i < 4; i++) begin
            if (base + i < 64 && w2_cnt - base == 4) begin
                checks++; if (w2_addr[base+i] !== 2'(i) || w2_data[base+i] !== 32'(i + 1)) begin failures++;
                    $display("FAIL full_write%0d got %h@%0d exp %h@%0d", i, w2_data[base+i], w2_addr[base+i], i + 1, i); end
            end
        end
        checks++; if (d2_done !== 1'b1 || d2_full !== 1'b1) begin failures++;
            $display("FAIL full_flags got %b%b exp 11", d2_done, d2_full); end
        checks++; if (d2_addr !== 2'd3) begin failures++; $display("FAIL full_addr got %0d exp 3", d2_addr); end
        for (int i = 0; i < 4; i++) send(8'h77);
        cycle(); cycle();
        checks++; if (w2_cnt - base !== 4 || d2_addr !== 2'd3) begin failures++;
            $display("FAIL full_ignored got writes=%0d addr=%0d exp 4 3", w2_cnt - base, d2_addr); end
    endtask

    task automatic test_enable_drop();
        do_reset();
        send(8'hAA); send(8'hBB);
        checks++; if (d0_busy !== 1'b1) begin failures++; $display("FAIL drop_busy_before got %b exp 1", d0_busy); end
        en = 1'b0; #1;
        checks++; if (d0_busy !== 1'b0) begin failures++; $display("FAIL drop_busy_now got %b exp 0", d0_busy); end
        cycle(); cycle();
        checks++; if (d0_busy !== 1'b0 || d0_addr !== 10'd0) begin failures++;
            $display("FAIL drop_disabled got busy=%b addr=%0d exp 0 0", d0_busy, d0_addr); end
        en = 1'b1;
        cycle();
        frm = 8'h01; vld = 1'b1; cycle();
        frm = 8'h02; cycle();
        frm = 8'h03; cycle();
        frm = 8'h04; cycle();
        vld = 1'b0;
        checks++; if (d0_we !== 1'b1 || d0_data !== 32'h0403_0201 || d0_addr !== 10'd0) begin failures++;
            $display("FAIL drop_reload got we=%b %h@%0d exp 1 04030201@0", d0_we, d0_data, d0_addr); end
    endtask

    task automatic test_reset_in_write();
        do_reset();
        send(8'h10); send(8'h20); send(8'h30); send(8'h40);
        checks++; if (d0_we !== 1'b1) begin failures++; $display("FAIL rstw_we_before got %b exp 1", d0_we); end
        rst = 1'b1;
        cycle();
        checks++; if ({d0_we, d0_busy, d0_done, d0_full} !== 4'b0 || d0_data !== 32'h0 || d0_addr !== 10'd0) begin failures++;
            $display("FAIL rstw_outputs got we=%b data=%h addr=%0d exp 0 0 0", d0_we, d0_data, d0_addr); end
        rst = 1'b0;
        cycle();
        send(8'h01); send(8'h00); send(8'h00); send(8'h00);
        checks++; if (d0_we !== 1'b1 || d0_addr !== 10'd0 || d0_data !== 32'h1) begin failures++;
            $display("FAIL rstw_restart got we=%b %h@%0d exp 1 00000001@0", d0_we, d0_data, d0_addr); end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; vld = 1'b0; frm = 8'h00;
        test_reset();
        test_single_word();
        test_back_to_back_end();
        test_narrow_word();
        test_mem_full();
        test_enable_drop();
        test_reset_in_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/debug_frame_loader.md
Name: debug_frame_loader

Overview:
- Host-to-MIPS direction of the debug frame interface: collects NB_FRAME-wide frames arriving from the debug interface (UART rx side) and packs them into NB_OUTPUT_SIZE-wide words.
- Each completed word is written to the instruction memory at an auto-incrementing address.
- Frame order is least-significant chunk first (chunk 0 = bits [NB_FRAME-1:0]), the same order the debug controllers use to send data out.
- Loading stops when the end-of-program word is written or memory is full.

Parameters:
NB_FRAME, 8, width of one incoming frame
NB_OUTPUT_SIZE, 32, width of one assembled memory word
NB_ADDR, 10, memory word-address width
END_WORD, 32'hFFFF_FFFF, word value marking end of program (MIPS halt)

Ports:
i_clock  input  1  clock
i_reset  input  1  synchronous, active-high reset
i_enable  input  1  load mode; low = block idle and cleared
i_frame  input  NB_FRAME  incoming frame
i_frame_valid  input  1  one-cycle strobe, i_frame valid
o_data  output  NB_OUTPUT_SIZE  assembled word to memory
o_addr  output  NB_ADDR  word address to memory
o_write_enable  output  1  one-cycle memory write strobe
o_busy  output  1  partial word held (frame count != 0)
o_done  output  1  sticky: end word written or memory full
o_full  output  1  sticky: done because last address written

Behaviour:
- Derived constant FRAMES_PER_WORD = ceil(NB_OUTPUT_SIZE/NB_FRAME).
- NB_PADDED = FRAMES_PER_WORD*NB_FRAME. Bits of the last frame above NB_OUTPUT_SIZE are discarded.
- Reset, or i_enable low: frame counter=0, word register=0, address=0, and all outputs 0 (o_data, o_addr, o_write_enable, o_busy, o_done, o_full). This applies every cycle i_enable is low, so dropping i_enable mid-word or mid-program aborts the load completely.
- Accept condition: i_enable & i_frame_valid & ~o_done. Frames failing this condition are ignored and change no state.
- On accept with frame counter k: i_frame goes into padded slot k, and k increments.
- When k == FRAMES_PER_WORD-1 at accept:
  - The counter wraps to 0 and o_data latches the full word.
  - o_write_enable is high for exactly the next cycle, with o_addr = current address.
  - Latency: final-frame accept edge to write strobe is 1 cycle.
- At the edge ending a write cycle:
  - Address increments (NB_ADDR bits).
  - If o_data == END_WORD: set o_done.
  - Else if address == 2^NB_ADDR-1: set o_done and o_full; the address does not wrap (stays at max).
  - The END_WORD check takes priority, so o_full stays 0 when the end word lands on the last address.
- A frame accepted during the write cycle is valid and starts the next word. o_data is held stable until the next word completes.
- FRAMES_PER_WORD=1: a word is emitted on every accepted frame, and back-to-back strobes give consecutive writes.
- o_done remains high until i_enable is low or reset. While done, frames are ignored and o_busy=0.
- Reset has priority over every other event.

Decomposition:
- Package debug_pkg:
  - Function for frames-per-word / padding (ceil division)
  - Default END_WORD (halt opcode) constant
  - Shared NB_FRAME/NB_OUTPUT_SIZE defaults with the debug controllers
- Sub-module debug_frame_packer:
  - Owns the frame counter and slot write, and emits a word-complete pulse plus the packed word.
  - The top level holds the address counter, write strobe and done/full flags.

Test Plan:
- Defaults, i_enable=1, frames 0x78,0x56,0x34,0x12 with 2 idle cycles between -> single write o_data=32'h1234_5678, o_addr=0, o_write_enable high one cycle, 1 cycle after 4th frame; o_busy high after frames 1-3.
- Two words then END_WORD (8 frames + 4x 0xFF), back-to-back strobes -> writes at addr 0,1,2; o_done=1, o_full=0 after third write; further frames produce no write.
- NB_OUTPUT_SIZE=20, NB_FRAME=8: frames 0xCD,0xAB,0xF9 -> o_data=20'h9ABCD (upper nibble of 0xF9 dropped), 1 write.
- NB_ADDR=2: four non-end words -> writes at addr 0..3, then o_done=o_full=1, o_addr held at 3; fifth word ignored.
- Drop i_enable after 2 frames of a word, re-enable, send 4 frames -> write at addr 0 holding only the new 4 frames; o_busy=0 while disabled.
- i_reset asserted in the write cycle -> o_write_enable 0 next cycle, all outputs 0, address 0.
